// File: rtl/mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module     : mem_loader_if
// Description: Bundles the loader's byte-stream input (rx_data/rx_valid/
//              rx_ready) and the instruction-memory loader write port
//              (mem_loader_write_addr/data/en).
//              master : the loader (consumes RX bytes, drives memory writes)
//              slave  : the environment (RX source + instruction memory)
// Revision   : 1.0 - initial release
// ============================================================================
interface mem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_loader_write_addr;
    logic [7:0]  mem_loader_write_data;
    logic        mem_loader_write_en;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_loader_write_addr,
        output mem_loader_write_data,
        output mem_loader_write_en
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_loader_write_addr,
        input  mem_loader_write_data,
        input  mem_loader_write_en
    );
endinterface
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module     : mem_loader
// Description: Byte-stream program loader. Parses frames of the form
//              MAGIC, 4-byte little-endian length, payload[, checksum]
//              and writes each payload byte to the instruction memory's
//              loader port. Holds the CPU in reset while a frame is in
//              progress and after a rejected frame.
//              Optional feature macro: MEM_LOADER_CHECKSUM_EN -- when
//              defined, a trailing checksum byte is required such that
//              (sum(payload) + checksum) mod 256 == 0.
// Ports      : clk        - system clock
//              rst_n      - asynchronous active-low reset
//              bus        - mem_loader_if.master (RX stream + write port)
//              cpu_rst_n  - active-low CPU reset request
//              busy       - frame in progress
//              done       - last frame loaded successfully (sticky)
//              error      - last frame rejected (sticky)
// Revision   : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int unsigned MEMORY_SIZE = 8196,
    parameter logic [7:0]  MAGIC       = 8'hA5,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_loader_if.master bus,
    output logic         cpu_rst_n,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
`ifdef MEM_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [31:0] c_mem_size = 32'(MEMORY_SIZE);

    // State reached once the payload (possibly empty) has been consumed.
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t c_after_payload = S_CSUM;
`else
    localparam state_t c_after_payload = S_DONE;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_len;
    logic [1:0]  r_len_idx;
    logic [31:0] r_cnt;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [7:0]  r_wr_data;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_acc;
    logic [7:0]  w_csum_total;
`endif

    // Bytes are never back-pressured, so every valid byte is consumed.
    logic        w_fire;
    logic        w_start;
    logic        w_last_data;
    logic [31:0] w_len_full;

    assign bus.rx_ready = 1'b1;
    assign w_fire       = bus.rx_valid;
    assign w_start      = w_fire && (bus.rx_data == MAGIC);
    assign w_last_data  = (r_cnt == (r_len - 32'd1));
    // Full length as it will be once the current (4th) length byte lands.
    assign w_len_full   = {bus.rx_data, r_len[23:0]};
`ifdef MEM_LOADER_CHECKSUM_EN
    assign w_csum_total = r_acc + bus.rx_data;
`endif

    assign bus.mem_loader_write_en   = r_wr_en;
    assign bus.mem_loader_write_addr = r_wr_addr;
    assign bus.mem_loader_write_data = r_wr_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        cpu_rst_n    = 1'b1;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_start) begin
                    w_state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_fire && (r_len_idx == 2'd3)) begin
                    if (w_len_full > c_mem_size) begin
                        w_state_next = S_ERROR;
                    end else if (w_len_full == 32'd0) begin
                        w_state_next = c_after_payload;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_fire && w_last_data) begin
                    w_state_next = c_after_payload;
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_fire) begin
                    w_state_next = (w_csum_total == 8'h00) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase

        // Status is a pure decode of the registered state, so it changes
        // on the same edge that the state does.
        case (r_state)
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            S_IDLE:  ;
            default: busy  = 1'b1;
        endcase
        cpu_rst_n = !(busy || error);
    end

    // ------------------------------------------------------------------
    // Datapath: length capture, payload indexing, registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= 32'd0;
            r_len_idx <= 2'd0;
            r_cnt     <= 32'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 32'd0;
            r_wr_data <= 8'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
            r_acc     <= 8'd0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_start) begin
                        r_len_idx <= 2'd0;
                        r_cnt     <= 32'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
                        r_acc     <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (w_fire) begin
                        r_len[{r_len_idx, 3'b000} +: 8] <= bus.rx_data;
                        r_len_idx                       <= r_len_idx + 2'd1;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= BASE_ADDR + r_cnt;
                        r_wr_data <= bus.rx_data;
                        r_cnt     <= r_cnt + 32'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                        r_acc     <= r_acc + bus.rx_data;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_loader
// Description: Self-checking bench for mem_loader. Frames are built from a
//              payload queue; the expected memory writes are simply the
//              payload bytes enumerated from BASE, and the expected outcome
//              comes from the frame rules (length bound, optional checksum).
//              Follows MEM_LOADER_CHECKSUM_EN the same way as the design.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

    localparam int unsigned MEM_SIZE = 8196;
    localparam logic [7:0]  MAGIC    = 8'hA5;
    localparam logic [31:0] BASE     = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n, busy, done, error;

    mem_loader_if bus();

    mem_loader #(
        .MEMORY_SIZE (MEM_SIZE),
        .MAGIC       (MAGIC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Captured memory writes (sampled mid-cycle)
    logic [31:0] cap_addr[$];
    logic [7:0]  cap_data[$];
    int          cap_cyc[$];

    always @(negedge clk) begin
        if (bus.mem_loader_write_en !== 1'b0) begin
            cap_addr.push_back(bus.mem_loader_write_addr);
            cap_data.push_back(bus.mem_loader_write_data);
            cap_cyc.push_back(cyc);
        end
    end

    logic [7:0] tx_pl[$];

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic gap(input int gmax);
        if (gmax > 0) idle($urandom_range(gmax, 0));
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    // Sends MAGIC, length, payload from tx_pl and (if enabled) checksum.
    // Payload and checksum are skipped when the length is out of bounds.
    task automatic send_frame(input logic [31:0] len, input logic [7:0] csum,
                              input int gmax);
        send_byte(MAGIC);
        for (int k = 0; k < 4; k++) begin
            gap(gmax);
            send_byte(len[8*k +: 8]);
        end
        if (len <= MEM_SIZE) begin
            foreach (tx_pl[k]) begin
                gap(gmax);
                send_byte(tx_pl[k]);
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            gap(gmax);
            send_byte(csum);
`endif
        end
    endtask

    function automatic logic [7:0] good_csum();
        logic [7:0] s;
        s = 8'h00;
        foreach (tx_pl[k]) s = s + tx_pl[k];
        return 8'(8'h00 - s);
    endfunction

    // Reference outcome of a frame: accepted or rejected.
    function automatic bit model_ok(input logic [31:0] len, input logic [7:0] csum);
        if (len > MEM_SIZE) return 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
        return (csum == good_csum());
`else
        return 1'b1;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_checks++; if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready got=%b exp=1", bus.rx_ready); end
        rst_n = 1'b1;
        idle(2);
        n_checks++; if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready_post got=%b exp=1", bus.rx_ready); end
        n_checks++; if (bus.mem_loader_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", bus.mem_loader_write_en); end
        n_checks++; if (bus.mem_loader_write_addr !== 32'd0) begin n_fail++; $display("FAIL reset_wr_addr got=%h exp=0", bus.mem_loader_write_addr); end
        n_checks++; if (bus.mem_loader_write_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data got=%h exp=0", bus.mem_loader_write_data); end
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1000) begin n_fail++; $display("FAIL reset_status got=%b exp=1000", {cpu_rst_n, busy, done, error}); end
    endtask

    task automatic test_noise();
        clear_cap();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        idle(2);
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1000) begin n_fail++; $display("FAIL noise_status got=%b exp=1000", {cpu_rst_n, busy, done, error}); end
        n_checks++; if (cap_addr.size() != 0) begin n_fail++; $display("FAIL noise_writes got=%0d exp=0", cap_addr.size()); end
    endtask

    task automatic test_example();
        logic [7:0] pl [4];
        int errs;
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        clear_cap();
        send_byte(MAGIC);
        n_checks++; if ({busy, cpu_rst_n} !== 2'b10) begin n_fail++; $display("FAIL ex_busy_after_magic got=%b exp=10", {busy, cpu_rst_n}); end
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int k = 0; k < 4; k++) send_byte(pl[k]);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(8'hED);
`endif
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1010) begin n_fail++; $display("FAIL ex_status got=%b exp=1010", {cpu_rst_n, busy, done, error}); end
        idle(1);
        n_checks++; if (cap_addr.size() != 4) begin n_fail++; $display("FAIL ex_write_count got=%0d exp=4", cap_addr.size()); end
        errs = 0;
        for (int k = 0; k < cap_addr.size() && k < 4; k++)
            if (cap_addr[k] !== BASE + 32'(k) || cap_data[k] !== pl[k]) errs++;
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL ex_write_content got=%0d bad exp=0 bad", errs); end
    endtask

    task automatic test_back_to_back();
        int errs;
        tx_pl.delete();
        for (int k = 0; k < 6; k++) tx_pl.push_back(8'($urandom));
        clear_cap();
        send_frame(32'd6, good_csum(), 0);
        idle(1);
        n_checks++; if (cap_addr.size() != 6) begin n_fail++; $display("FAIL b2b_write_count got=%0d exp=6", cap_addr.size()); end
        errs = 0;
        for (int k = 1; k < cap_cyc.size(); k++)
            if (cap_cyc[k] != cap_cyc[k-1] + 1) errs++;
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL b2b_strobe_gaps got=%0d exp=0", errs); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", done); end
    endtask

    task automatic test_len_zero();
        tx_pl.delete();
        clear_cap();
        send_frame(32'd0, 8'h00, 1);
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1010) begin n_fail++; $display("FAIL len0_status got=%b exp=1010", {cpu_rst_n, busy, done, error}); end
        idle(2);
        n_checks++; if (cap_addr.size() != 0) begin n_fail++; $display("FAIL len0_writes got=%0d exp=0", cap_addr.size()); end
    endtask

    task automatic test_len_bound();
        logic [31:0] bad_lens [2];
        int errs;
        bad_lens = '{32'd8197, 32'h0001_0004};
        foreach (bad_lens[j]) begin
            tx_pl.delete();
            clear_cap();
            send_frame(bad_lens[j], 8'h00, 1);
            n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b0001) begin n_fail++; $display("FAIL lenbound_reject_%0d got=%b exp=0001", j, {cpu_rst_n, busy, done, error}); end
            idle(2);
            n_checks++; if (cap_addr.size() != 0) begin n_fail++; $display("FAIL lenbound_writes_%0d got=%0d exp=0", j, cap_addr.size()); end
        end
        // Exactly MEMORY_SIZE bytes is accepted
        tx_pl.delete();
        for (int k = 0; k < int'(MEM_SIZE); k++) tx_pl.push_back(8'($urandom));
        clear_cap();
        send_frame(32'(MEM_SIZE), good_csum(), 0);
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1010) begin n_fail++; $display("FAIL lenmax_status got=%b exp=1010", {cpu_rst_n, busy, done, error}); end
        idle(1);
        n_checks++; if (cap_addr.size() != int'(MEM_SIZE)) begin n_fail++; $display("FAIL lenmax_count got=%0d exp=%0d", cap_addr.size(), MEM_SIZE); end
        errs = 0;
        for (int k = 0; k < cap_addr.size() && k < int'(MEM_SIZE); k++)
            if (cap_addr[k] !== BASE + 32'(k) || cap_data[k] !== tx_pl[k]) errs++;
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL lenmax_content got=%0d bad exp=0 bad", errs); end
    endtask

`ifdef MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        tx_pl.delete();
        tx_pl.push_back(8'h01);
        tx_pl.push_back(8'h02);
        clear_cap();
        send_frame(32'd2, 8'h00, 1);
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b0001) begin n_fail++; $display("FAIL csum_bad_status got=%b exp=0001", {cpu_rst_n, busy, done, error}); end
        idle(1);
        n_checks++; if (cap_addr.size() != 2) begin n_fail++; $display("FAIL csum_bad_writes got=%0d exp=2", cap_addr.size()); end
        clear_cap();
        send_frame(32'd2, 8'hFD, 1);
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1010) begin n_fail++; $display("FAIL csum_good_status got=%b exp=1010", {cpu_rst_n, busy, done, error}); end
    endtask
`endif

    task automatic test_mid_reset();
        logic [7:0] first [3];
        int errs;
        clear_cap();
        send_byte(MAGIC);
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        for (int k = 0; k < 3; k++) begin
            first[k] = 8'($urandom);
            send_byte(first[k]);
        end
        @(negedge clk);
        #1;
        n_checks++; if (cap_addr.size() != 3) begin n_fail++; $display("FAIL midrst_partial_count got=%0d exp=3", cap_addr.size()); end
        errs = 0;
        for (int k = 0; k < cap_addr.size() && k < 3; k++)
            if (cap_addr[k] !== BASE + 32'(k) || cap_data[k] !== first[k]) errs++;
        n_checks++; if (errs != 0) begin n_fail++; $display("FAIL midrst_partial_content got=%0d bad exp=0 bad", errs); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1000) begin n_fail++; $display("FAIL midrst_status got=%b exp=1000", {cpu_rst_n, busy, done, error}); end
        n_checks++; if ({bus.mem_loader_write_en, bus.mem_loader_write_addr, bus.mem_loader_write_data} !== 41'd0) begin n_fail++; $display("FAIL midrst_wrport got=%h exp=0", {bus.mem_loader_write_en, bus.mem_loader_write_addr, bus.mem_loader_write_data}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tx_pl.delete();
        for (int k = 0; k < 8; k++) tx_pl.push_back(8'($urandom));
        clear_cap();
        send_frame(32'd8, good_csum(), 1);
        n_checks++; if ({cpu_rst_n, busy, done, error} !== 4'b1010) begin n_fail++; $display("FAIL midrst_restart got=%b exp=1010", {cpu_rst_n, busy, done, error}); end
        idle(1);
        n_checks++; if (cap_addr.size() != 8) begin n_fail++; $display("FAIL midrst_restart_count got=%0d exp=8", cap_addr.size()); end
    endtask

    task automatic test_random();
        logic [31:0] len;
        logic [7:0]  csum;
        bit          exp_ok;
        int          errs;
        for (int f = 0; f < 25; f++) begin
            len = 32'($urandom_range(48, 1));
            tx_pl.delete();
            for (int k = 0; k < int'(len); k++)
                tx_pl.push_back(($urandom_range(3, 0) == 0) ? MAGIC : 8'($urandom));
            csum = good_csum();
            if ($urandom_range(3, 0) == 0) csum = csum ^ 8'(1 << $urandom_range(7, 0));
            repeat ($urandom_range(2, 0)) send_byte(8'($urandom_range(8'hA4, 0)));
            exp_ok = model_ok(len, csum);
            clear_cap();
            send_frame(len, csum, 2);
            n_checks++;
            if ({cpu_rst_n, busy, done, error} !== {exp_ok, 1'b0, exp_ok, !exp_ok}) begin
                n_fail++;
                $display("FAIL rand_status f=%0d got=%b exp=%b", f, {cpu_rst_n, busy, done, error}, {exp_ok, 1'b0, exp_ok, !exp_ok});
            end
            idle(1);
            n_checks++; if (cap_addr.size() != int'(len)) begin n_fail++; $display("FAIL rand_count f=%0d got=%0d exp=%0d", f, cap_addr.size(), len); end
            errs = 0;
            for (int k = 0; k < cap_addr.size() && k < int'(len); k++)
                if (cap_addr[k] !== BASE + 32'(k) || cap_data[k] !== tx_pl[k]) errs++;
            n_checks++; if (errs != 0) begin n_fail++; $display("FAIL rand_content f=%0d got=%0d bad exp=0 bad", f, errs); end
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_noise();
        test_example();
        test_back_to_back();
        test_len_zero();
        test_len_bound();
`ifdef MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
